// File: rtl/i2c_target_regs_if.sv
// Fabric-side view of the I2C register target: the register bank contents,
// the per-byte write strobe with its register index, and the bus-busy flag.
interface i2c_target_regs_if #(
    parameter int NUM_REGS = 4
);
    logic [8*NUM_REGS-1:0] regOut;
    logic                  wrStrobe;
    logic [7:0]            wrAddr;
    logic                  busy;

    // The I2C target produces this view
    modport slave  (output regOut, output wrStrobe, output wrAddr, output busy);
    // Fabric logic consumes it
    modport master (input  regOut, input  wrStrobe, input  wrAddr, input  busy);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers. Protocol: device address,
// register pointer, then data bytes with pointer auto-increment; reads return
// regOut[pointer] with the same auto-increment. SCL and SDA pass through a
// 2-FF synchronizer and a FILTER_LEN-deep glitch filter (FILTER_LEN >= 2);
// all bus decisions are made on the filtered levels.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h42,
    parameter int         NUM_REGS   = 4,
    parameter int         FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl,
    inout  wire              sda,
    i2c_target_regs_if.slave bus
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AACK,
        ST_PTR,
        ST_PACK,
        ST_WDATA,
        ST_DACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_t;

    // ---------------- input conditioning ----------------
    // index 0 = SCL, index 1 = SDA
    logic                        sda_in;
    logic [1:0]                  sync1_q, sync2_q;
    logic [1:0][FILTER_LEN-2:0]  hist_q;
    logic [1:0][FILTER_LEN-1:0]  win;
    logic [1:0]                  filt_q, prev_q;

    assign sda_in = sda;

    // The window is the newest synchronized sample plus FILTER_LEN-1 older ones;
    // a level change is accepted only when the whole window agrees.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            win[i] = {hist_q[i], sync2_q[i]};
        end
    end

    // Synchronize, filter and keep the previous filtered level for edge detect.
    // Reset to the idle-bus level (both high) so no false edge is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '1;
            filt_q  <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= {sda_in, scl};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                hist_q[i] <= win[i][FILTER_LEN-2:0];
                if (&win[i])
                    filt_q[i] <= 1'b1;
                else if (~|win[i])
                    filt_q[i] <= 1'b0;
            end
            prev_q <= filt_q;
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise =  filt_q[0] & ~prev_q[0];
    assign scl_fall = ~filt_q[0] &  prev_q[0];
    // SDA may only change as a START/STOP while SCL is steadily high, so an
    // event can never share a cycle with a data-bit SCL edge.
    assign start_ev = scl_f & prev_q[0] &  prev_q[1] & ~sda_f;
    assign stop_ev  = scl_f & prev_q[0] & ~prev_q[1] &  sda_f;

    // ---------------- protocol FSM ----------------
    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [7:0]                 rxsh_q, rxsh_d;
    logic [7:0]                 txsh_q, txsh_d;
    logic                       oe_q, oe_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic                       rw_q, rw_d;
    logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
    logic                       stb_q, stb_d;
    logic [7:0]                 waddr_q, waddr_d;
    logic [7:0]                 rx_byte;
    logic                       ptr_ok;

    assign rx_byte = {rxsh_q[6:0], sda_f};
    assign ptr_ok  = (rxsh_q[7:PW] == '0);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rxsh_q  <= '0;
            txsh_q  <= '0;
            oe_q    <= 1'b0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            regs_q  <= '0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rxsh_q  <= rxsh_d;
            txsh_q  <= txsh_d;
            oe_q    <= oe_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            regs_q  <= regs_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
        end
    end

    // Next state: bus events first, then per-state bit handling on SCL edges.
    // cnt counts SCL rising edges within the current byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rxsh_d  = rxsh_q;
        txsh_d  = txsh_q;
        oe_d    = oe_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        regs_d  = regs_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;

        if (stop_ev) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else if (start_ev) begin
            state_d = ST_ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        rxsh_d = rx_byte;
                        cnt_d  = cnt_q + 4'd1;
                        // Commit on the 8th rising edge; a partial byte never gets here
                        if (state_q == ST_WDATA && cnt_q == 4'd7) begin
                            regs_d[ptr_q] = rx_byte;
                            stb_d         = 1'b1;
                            waddr_d       = 8'(ptr_q);
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_ADDR: begin
                                if (rxsh_q[7:1] == DEV_ADDR) begin
                                    oe_d    = 1'b1;
                                    rw_d    = rxsh_q[0];
                                    state_d = ST_AACK;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end
                            ST_PTR: begin
                                if (ptr_ok) begin
                                    ptr_d   = rxsh_q[PW-1:0];
                                    oe_d    = 1'b1;
                                    state_d = ST_PACK;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end
                            default: begin
                                oe_d    = 1'b1;
                                ptr_d   = ptr_q + 1'b1;
                                state_d = ST_DACK;
                            end
                        endcase
                    end
                end
                ST_AACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            // Bit 7 goes out on the same edge that ends our ACK
                            txsh_d  = regs_q[ptr_q];
                            oe_d    = ~regs_q[ptr_q][7];
                            state_d = ST_RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = ST_PTR;
                        end
                    end
                end
                ST_PACK, ST_DACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_RACK;
                        end else begin
                            txsh_d = {txsh_q[6:0], 1'b0};
                            oe_d   = ~txsh_q[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        // Pointer advances on ACK and NACK alike
                        ptr_d = ptr_q + 1'b1;
                        if (sda_f)
                            state_d = ST_IGNORE;
                        else
                            cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        txsh_d  = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // Open-drain output; reset releases the line without waiting for a clock
    assign sda = (oe_q && !reset) ? 1'b0 : 1'bz;

    assign bus.regOut   = regs_q;
    assign bus.wrStrobe = stb_q;
    assign bus.wrAddr   = waddr_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule
